// File: rtl/vga_timing_ctrl_if.sv
// Interface between the timing controller and its config/video neighbours.
// The master side drives config and pixel enable; the slave side is the controller.
interface vga_timing_ctrl_if #(
  parameter int CW = 11
);
  logic          en;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          cfg_commit;
  logic          cfg_pending;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output en, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_pending, hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    input  en, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_pending, hsync, vsync, de, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Programmable VGA timing generator: per-axis phase FSMs driven by a
// double-buffered timing bank that only swaps on a frame boundary.
module vga_timing_ctrl #(
  parameter int CW                = 11,
  parameter int HSYNC_ACTIVE_HIGH = 0,
  parameter int VSYNC_ACTIVE_HIGH = 0,
  parameter int H_ACT             = 640,
  parameter int H_FP              = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BP              = 48,
  parameter int V_ACT             = 480,
  parameter int V_FP              = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BP              = 33
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_ACT  = 2'd0;
  localparam logic [1:0] ST_FP   = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;
  localparam logic [1:0] ST_BP   = 2'd3;

  logic [1:0]    hState_q, hState_d;
  logic [1:0]    vState_q, vState_d;
  logic [CW-1:0] hCnt_q, hCnt_d;
  logic [CW-1:0] vCnt_q, vCnt_d;
  logic [CW-1:0] stage_q [8];
  logic [CW-1:0] stage_d [8];
  logic [CW-1:0] act_q [8];
  logic [CW-1:0] act_d [8];
  logic          pending_q, pending_d;

  logic [CW-1:0] hLen, vLen;
  logic          hLast, vLast, hEol, frameEnd;

  function automatic logic [CW-1:0] defLen(input int idx);
    case (idx)
      0:       return CW'(H_ACT);
      1:       return CW'(H_FP);
      2:       return CW'(H_SYNC);
      3:       return CW'(H_BP);
      4:       return CW'(V_ACT);
      5:       return CW'(V_FP);
      6:       return CW'(V_SYNC);
      default: return CW'(V_BP);
    endcase
  endfunction

  function automatic logic [1:0] nextState(input logic [1:0] s);
    case (s)
      ST_ACT:  return ST_FP;
      ST_FP:   return ST_SYNC;
      ST_SYNC: return ST_BP;
      default: return ST_ACT;
    endcase
  endfunction

  // Bank index is {axis, phase}: H lengths live at 0-3, V lengths at 4-7.
  always_comb begin
    hLen     = act_q[{1'b0, hState_q}];
    vLen     = act_q[{1'b1, vState_q}];
    hLast    = (hCnt_q == hLen - CW'(1));
    vLast    = (vCnt_q == vLen - CW'(1));
    hEol     = bus.en && (hState_q == ST_BP) && hLast;
    frameEnd = hEol && (vState_q == ST_BP) && vLast;
  end

  always_comb begin
    hState_d = hState_q;
    hCnt_d   = hCnt_q;
    vState_d = vState_q;
    vCnt_d   = vCnt_q;
    if (bus.en) begin
      if (hLast) begin
        hState_d = nextState(hState_q);
        hCnt_d   = '0;
      end else begin
        hCnt_d = hCnt_q + CW'(1);
      end
    end
    if (hEol) begin
      if (vLast) begin
        vState_d = nextState(vState_q);
        vCnt_d   = '0;
      end else begin
        vCnt_d = vCnt_q + CW'(1);
      end
    end
  end

  // A commit raised on the boundary cycle itself must survive the clear.
  always_comb begin
    stage_d = stage_q;
    if (bus.cfg_we) begin
      stage_d[bus.cfg_addr] = (bus.cfg_wdata == '0) ? CW'(1) : bus.cfg_wdata;
    end
    act_d = act_q;
    if (frameEnd && pending_q) begin
      act_d = stage_q;
    end
    pending_d = bus.cfg_commit | (pending_q & ~frameEnd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hState_q  <= ST_ACT;
      vState_q  <= ST_ACT;
      hCnt_q    <= '0;
      vCnt_q    <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stage_q[i] <= defLen(i);
        act_q[i]   <= defLen(i);
      end
    end else begin
      hState_q  <= hState_d;
      vState_q  <= vState_d;
      hCnt_q    <= hCnt_d;
      vCnt_q    <= vCnt_d;
      pending_q <= pending_d;
      stage_q   <= stage_d;
      act_q     <= act_d;
    end
  end

  // Strobes are masked during reset so an enabled reset never pulses them.
  assign bus.de          = (hState_q == ST_ACT) && (vState_q == ST_ACT);
  assign bus.x           = bus.de ? hCnt_q : '0;
  assign bus.y           = (vState_q == ST_ACT) ? vCnt_q : '0;
  assign bus.hsync       = (hState_q == ST_SYNC) ^ (HSYNC_ACTIVE_HIGH == 0);
  assign bus.vsync       = (vState_q == ST_SYNC) ^ (VSYNC_ACTIVE_HIGH == 0);
  assign bus.line_start  = ~rst && bus.en && (hState_q == ST_ACT) && (hCnt_q == '0);
  assign bus.frame_start = bus.line_start && (vState_q == ST_ACT) && (vCnt_q == '0);
  assign bus.cfg_pending = pending_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: a position-based reference model predicts every output
// bundle for a 640x480 instance and a small-timing instance each cycle.
module tb_vga_timing_ctrl;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst, en, we, commit;
  logic [2:0]    addr;
  logic [CW-1:0] wdata;

  always #5 clk = ~clk;

  vga_timing_ctrl_if #(.CW(CW)) busD ();
  vga_timing_ctrl_if #(.CW(CW)) busS ();

  assign busD.en = en;  assign busD.cfg_we = we;  assign busD.cfg_addr = addr;
  assign busD.cfg_wdata = wdata;  assign busD.cfg_commit = commit;
  assign busS.en = en;  assign busS.cfg_we = we;  assign busS.cfg_addr = addr;
  assign busS.cfg_wdata = wdata;  assign busS.cfg_commit = commit;

  vga_timing_ctrl #(.CW(CW)) dutD (.clk(clk), .rst(rst), .bus(busD));

  vga_timing_ctrl #(
    .CW(CW), .H_ACT(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACT(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dutS (.clk(clk), .rst(rst), .bus(busS));

  int checks   = 0;
  int failures = 0;
  logic [27:0] expQ [$];

  int defT [2][8] = '{'{640, 16, 96, 48, 480, 10, 2, 33}, '{6, 2, 3, 2, 3, 1, 2, 1}};
  int act  [2][8];
  int st   [2][8];
  bit pend [2];
  int hpos [2];
  int vline[2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int phaseOf(input int pos, input int a, input int f, input int s);
    if (pos < a) return 0;
    if (pos < a + f) return 1;
    if (pos < a + f + s) return 2;
    return 3;
  endfunction

  function automatic int hTot(input int i);
    return act[i][0] + act[i][1] + act[i][2] + act[i][3];
  endfunction

  function automatic int vTot(input int i);
    return act[i][4] + act[i][5] + act[i][6] + act[i][7];
  endfunction

  task automatic modelReset(input int i);
    for (int k = 0; k < 8; k++) begin
      act[i][k] = defT[i][k];
      st[i][k]  = defT[i][k];
    end
    pend[i]  = 1'b0;
    hpos[i]  = 0;
    vline[i] = 0;
  endtask

  function automatic logic [27:0] expected(input int i, input logic r, input logic e);
    int hp, vp;
    logic deE, lsE;
    logic [CW-1:0] xe, ye;
    hp  = phaseOf(hpos[i], act[i][0], act[i][1], act[i][2]);
    vp  = phaseOf(vline[i], act[i][4], act[i][5], act[i][6]);
    deE = (hp == 0) && (vp == 0);
    lsE = !r && e && (hpos[i] == 0);
    xe  = deE ? CW'(hpos[i]) : CW'(0);
    ye  = (vp == 0) ? CW'(vline[i]) : CW'(0);
    return {pend[i], hp != 2, vp != 2, deE, xe, ye, lsE, lsE && (vline[i] == 0)};
  endfunction

  function automatic logic [27:0] observed(input int i);
    if (i == 0)
      return {busD.cfg_pending, busD.hsync, busD.vsync, busD.de, busD.x, busD.y,
              busD.line_start, busD.frame_start};
    return {busS.cfg_pending, busS.hsync, busS.vsync, busS.de, busS.x, busS.y,
            busS.line_start, busS.frame_start};
  endfunction

  task automatic modelClock(input int i, input logic e, input logic w, input logic [2:0] a,
                            input logic [CW-1:0] d, input logic c);
    int ht, vt;
    bit bnd;
    ht  = hTot(i);
    vt  = vTot(i);
    bnd = e && (hpos[i] == ht - 1) && (vline[i] == vt - 1);
    if (bnd && pend[i]) begin
      for (int k = 0; k < 8; k++) act[i][k] = st[i][k];
    end
    if (w) st[i][a] = (d == 0) ? 1 : int'(d);
    pend[i] = c ? 1'b1 : (bnd ? 1'b0 : pend[i]);
    if (e) begin
      if (hpos[i] == ht - 1) begin
        hpos[i]  = 0;
        vline[i] = (vline[i] == vt - 1) ? 0 : vline[i] + 1;
      end else begin
        hpos[i] = hpos[i] + 1;
      end
    end
  endtask

  // One pixel period: drive at the falling edge, score at +1, then let the rising edge pass.
  task automatic applyStimulus(input logic r, input logic e, input logic w, input logic [2:0] a,
                               input logic [CW-1:0] d, input logic c);
    rst = r;  en = e;  we = w;  addr = a;  wdata = d;  commit = c;
    if (r) begin
      modelReset(0);
      modelReset(1);
    end
    expQ.push_back(expected(0, r, e));
    expQ.push_back(expected(1, r, e));
    #1;
    checkOutput("dflt_outputs", 32'(observed(0)), 32'(expQ.pop_front()));
    checkOutput("small_outputs", 32'(observed(1)), 32'(expQ.pop_front()));
    if (!r) begin
      modelClock(0, e, w, a, d, c);
      modelClock(1, e, w, a, d, c);
    end
    @(negedge clk);
  endtask

  task automatic runIdle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
  endtask

  initial begin
    bit found;
    rst = 1'b1;  en = 1'b0;  we = 1'b0;  addr = '0;  wdata = '0;  commit = 1'b0;
    modelReset(0);
    modelReset(1);
    @(negedge clk);

    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    runIdle(2500);
    checkOutput("x_at_line3", 32'(busD.x), 32'd100);
    checkOutput("y_at_line3", 32'(busD.y), 32'd3);

    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0);
    checkOutput("x_hold", 32'(busD.x), 32'd100);
    checkOutput("de_hold", 32'(busD.de), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    checkOutput("x_resume", 32'(busD.x), 32'd101);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
    checkOutput("pending_set", 32'(busD.cfg_pending), 32'd1);

    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (hpos[0] == 700 && vline[0] == 3) found = 1'b1;
      else runIdle(1);
    end
    checkOutput("seek_hsync", 32'(found), 32'd1);
    checkOutput("hsync_in_sync", 32'(busD.hsync), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    checkOutput("pending_rst", 32'(busD.cfg_pending), 32'd0);
    checkOutput("hsync_rst", 32'(busD.hsync), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    runIdle(1000);

    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, CW'(4), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, CW'(1), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, CW'(2), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, CW'(1), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, CW'(2), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd5, CW'(1), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, CW'(1), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd7, CW'(1), 1'b1);
    checkOutput("pending_small", 32'(busS.cfg_pending), 32'd1);
    runIdle(300);

    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, CW'(0), 1'b1);
    runIdle(200);

    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, CW'(3), 1'b0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (hpos[1] == hTot(1) - 1 && vline[1] == vTot(1) - 1 && !pend[1]) found = 1'b1;
      else runIdle(1);
    end
    checkOutput("seek_boundary", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b1);
    checkOutput("pending_after_bnd", 32'(busS.cfg_pending), 32'd1);
    runIdle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the horizontal and vertical pixel/line counters of the video output path.
- Generates hsync, vsync, display-enable (de), pixel coordinates and frame/line strobes from programmable timing registers.
- Timing is written through a simple register port into a staging bank and takes effect only at a frame boundary, so a timing change never produces a torn frame.
- Sits between the config bus and the pixel fetch/colour output stage.

Parameters:
- CW, 11, width of all counters, timing fields and x/y outputs.
- HSYNC_ACTIVE_HIGH, 0, 1 = hsync high during sync phase; 0 = low.
- VSYNC_ACTIVE_HIGH, 0, 1 = vsync high during sync phase; 0 = low.
- Reset/default timing (640x480): H_ACT=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACT=480, V_FP=10, V_SYNC=2, V_BP=33.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance timing by one pixel this cycle.
- cfg_we  in  1  write strobe into staging bank.
- cfg_addr  in  3  0-3 = H act/fp/sync/bp; 4-7 = V act/fp/sync/bp.
- cfg_wdata  in  CW  phase length (pixels for H, lines for V).
- cfg_commit  in  1  request staging→active copy at next frame boundary.
- cfg_pending  out  1  commit requested, not yet applied.
- hsync  out  1  horizontal sync, polarity per parameter.
- vsync  out  1  vertical sync, polarity per parameter.
- de  out  1  high when H and V are both in ACTIVE.
- x  out  CW  H count while de, else 0.
- y  out  CW  V count while V in ACTIVE, else 0.
- line_start  out  1  one-cycle pulse on first pixel of every line.
- frame_start  out  1  one-cycle pulse on pixel (0,0).

Behaviour:
- Per-axis FSM: ACTIVE→FRONT→SYNC→BACK→ACTIVE.
  - Each axis has a phase counter cnt counting 0..len-1.
  - At cnt==len-1 the axis moves to the next state with cnt=0.
- H axis steps on every clk with en=1.
- V axis steps only on H end-of-line: H in BACK, cnt==H_BP-1, en=1.
- Frame boundary: V end-of-line in BACK at cnt==V_BP-1.
- All outputs decode from registered state; no added latency. sync = (state==SYNC) XOR (not ACTIVE_HIGH).
- line_start = H ACTIVE, cnt 0, en=1.
- frame_start = line_start and V ACTIVE, cnt 0.
- en=0: counters, states and all level outputs hold; strobes held low.
- Config writes:
  - cfg_we writes staging[cfg_addr].
  - wdata=0 is stored as 1: every phase lasts at least one unit.
  - Staging is not visible to timing until commit.
- Commit:
  - cfg_commit sets pending (cfg_pending=1 the following cycle).
  - At a frame boundary with pending=1 (registered value), the active bank is loaded from staging and pending is cleared.
  - The next cycle starts the new frame at H ACTIVE/V ACTIVE, cnt 0.
  - A commit on the boundary cycle itself is applied at the following boundary.
  - cfg_we and cfg_commit in the same cycle: the write is included in that commit.
  - Writes while pending update staging and are applied at the same boundary.
- Reset (any time, including mid-line): both axes go to ACTIVE with cnt=0; staging and active banks reload defaults; pending=0.
  - Reset outputs: de=1, x=0, y=0, hsync/vsync inactive level, line_start=frame_start=0.
  - The first en cycle after reset release pulses line_start and frame_start.
- Width rule: counters and lengths are CW bits unsigned. Lengths up to 2^CW-1 are legal; no wrap occurs inside a phase.

Test Plan:
- Defaults, en=1 continuous:
  - line period 800 clk;
  - hsync low on H cycles 656..751;
  - de high on cycles 0..639, with x=0..639;
  - frame period 420000 clk;
  - vsync low on lines 490..491;
  - frame_start exactly once per frame.
- Write H=4/1/2/1 and V=2/1/1/1, then commit mid-frame:
  - cfg_pending stays 1 until the current 525-line frame ends;
  - next frame has line period 8 and frame period 40;
  - de pattern is 4 high / 4 low on lines 0..1.
- Write H_SYNC=0 and commit: sync phase is exactly 1 clk per line.
- Toggle en low for 5 cycles mid-ACTIVE at x=100: x, de and hsync hold; no strobes; resumes at x=101.
- Assert rst asynchronously mid-SYNC of line 3 with a commit pending:
  - outputs immediately show reset values;
  - pending=0;
  - default timing restored.
- Commit on the exact frame-boundary cycle: the new timing applies one frame later, not immediately.
